alu_unit: RTL

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_if.sv | 58 +++++
 rtl/alu_mul_iter.sv | 73 +++++++
 rtl/alu_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU unit slice.
//
// Contents:
//   ALU_DEFAULT_WIDTH : default operand/result width used by every module
//   alu_ctrl_e        : 3-bit operation codes carried on req_ctrl
//   alu_state_e       : control FSM states of alu_unit
//
// Optional feature macro: ALU_MUL_EN. When it is defined the FSM gets its
// BUSY state for the iterative multiplier. Without it the state set is IDLE
// and RESP only.
package alu_pkg;

  localparam int ALU_DEFAULT_WIDTH = 16;

  // Code 101 is left unassigned on purpose so that it always decodes as an
  // illegal request. OP_ILL only names it for readability.
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_XOR = 3'b100,
    OP_ILL = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_ctrl_e;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } alu_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd2
  } alu_state_e;
`endif

endpackage

// File: rtl/alu_if.sv
// alu_if -- request/response bundle between a requester and alu_unit.
//
// Signals:
//   req_valid / req_ready       request handshake
//   req_ctrl                    operation code (alu_ctrl_e encoding)
//   req_a / req_b               operands, WIDTH bits
//   rsp_valid / rsp_ready       response handshake
//   rsp_res                     result, WIDTH bits
//   rsp_zero                    result is all zeros
//   rsp_illegal                 request used an unsupported operation code
//
// Modports:
//   master : the requester, which drives the request and rsp_ready
//   slave  : the ALU, which drives req_ready and the response
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) ();

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_ctrl;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_zero;
  logic             rsp_illegal;

  modport master (
    output req_valid,
    output req_ctrl,
    output req_a,
    output req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_res,
    input  rsp_zero,
    input  rsp_illegal
  );

  modport slave (
    input  req_valid,
    input  req_ctrl,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_res,
    output rsp_zero,
    output rsp_illegal
  );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter -- iterative shift-add multiplier, one partial product per
// clock, returning the low WIDTH bits of the unsigned product.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   start_i    load a_i/b_i and begin a multiplication
//   a_i, b_i   operands, sampled only on the start cycle
//   done_o     product_o holds the finished product
//   product_o  low WIDTH bits of a_i * b_i
//
// Optional feature macro: ALU_MUL_EN. The module exists only when the macro
// is defined, so a default build contains no multiplier at all.
`ifdef ALU_MUL_EN
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;

  // The start edge already performs iteration 1 on the incoming operands.
  // Each following edge adds the next partial product until cnt_q reaches
  // WIDTH. That gives exactly WIDTH iterations, and the product is ready one
  // edge before the controller registers it into the response.
  // The accumulator is only WIDTH bits wide because the upper half of the
  // product is never returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(1);
      acc_q    <= b_i[0] ? a_i : '0;
      mcand_q  <= a_i << 1;
      mplier_q <= b_i >> 1;
    end else if (busy_q) begin
      if (cnt_q == CNT_W'(WIDTH)) begin
        busy_q <= 1'b0;
      end else begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign done_o    = busy_q && (cnt_q == CNT_W'(WIDTH));
  assign product_o = acc_q;

endmodule
`endif

// File: rtl/alu_unit.sv
// alu_unit -- registered ALU with a valid/ready request and response
// handshake.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   alu_if.slave:
//           req_valid/req_ready, req_ctrl, req_a, req_b  (request)
//           rsp_valid/rsp_ready, rsp_res, rsp_zero, rsp_illegal (response)
//
// Operations: AND, OR, ADD, XOR, SUB, SLT (signed set-less-than), and MUL
// when enabled. Code 101 always answers as illegal with a zero result.
//
// Optional feature macro: ALU_MUL_EN. When it is defined, MUL goes through
// the BUSY state and the alu_mul_iter sub-module, and its latency is WIDTH+1.
// Without it, MUL answers as illegal and every response has latency 1.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);

  alu_state_e       state_q;
  alu_state_e       state_d;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             zero_q;
  logic             zero_d;
  logic             illegal_q;
  logic             illegal_d;

  logic             accept;
  logic [WIDTH-1:0] opRes;
  logic             opIllegal;

`ifdef ALU_MUL_EN
  logic             isMul;
  logic             mulStart;
  logic             mulDone;
  logic [WIDTH-1:0] mulProduct;

  assign isMul = (alu_ctrl_e'(bus.req_ctrl) == OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mulStart),
    .a_i      (bus.req_a),
    .b_i      (bus.req_b),
    .done_o   (mulDone),
    .product_o(mulProduct)
  );
`endif

  // A new request can be taken while idle. It can also be taken in the same
  // cycle that the current response leaves, which removes any bubble between
  // back-to-back requests. req_ready is held low during reset so that nothing
  // appears to be accepted while the state is being cleared.
  assign bus.req_ready = !rst &&
                         ((state_q == ST_IDLE) ||
                          ((state_q == ST_RESP) && bus.rsp_ready));
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.rsp_res     = res_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.rsp_illegal = illegal_q;

  // Single-cycle datapath. It works on the live request bus, and its result
  // is registered only on the accept edge. Operand changes after that edge
  // therefore cannot reach the response. Unknown codes, and MUL when the
  // multiplier is not built, fall through to the illegal default.
  always_comb begin
    opRes     = '0;
    opIllegal = 1'b0;
    case (alu_ctrl_e'(bus.req_ctrl))
      OP_AND: opRes = bus.req_a & bus.req_b;
      OP_OR:  opRes = bus.req_a | bus.req_b;
      OP_ADD: opRes = bus.req_a + bus.req_b;
      OP_XOR: opRes = bus.req_a ^ bus.req_b;
      OP_SUB: opRes = bus.req_a - bus.req_b;
      OP_SLT: opRes = {{(WIDTH-1){1'b0}},
                       ($signed(bus.req_a) < $signed(bus.req_b))};
`ifdef ALU_MUL_EN
      OP_MUL: opRes = '0;
`endif
      default: begin
        opRes     = '0;
        opIllegal = 1'b1;
      end
    endcase
  end

  // Next-state and response-register logic. IDLE and RESP share the accept
  // path, because an accept in RESP always coincides with the response
  // transfer. A RESP cycle whose response transfers without a new request
  // returns to IDLE. In RESP without rsp_ready every register keeps its
  // value, so the response stays stable until it is taken.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_MUL_EN
    mulStart  = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (isMul) begin
            state_d  = ST_BUSY;
            mulStart = 1'b1;
          end else
`endif
          begin
            state_d   = ST_RESP;
            res_d     = opRes;
            zero_d    = (opRes == '0);
            illegal_d = opIllegal;
          end
        end else if ((state_q == ST_RESP) && bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      ST_BUSY: begin
        if (mulDone) begin
          state_d   = ST_RESP;
          res_d     = mulProduct;
          zero_d    = (mulProduct == '0);
          illegal_d = 1'b0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and response registers. Reset drops any operation in flight and
  // any pending response at once. The reset value of the result is zero,
  // so the zero flag resets high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      res_q     <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
